// File: rtl/tick_scheduler.sv
// Four-channel event scheduler sharing one base-tick prescaler.
// Channels count base ticks and emit one-cycle strobes, periodic or one-shot.
module tick_scheduler #(
    parameter int BASE_DIV = 12500000,
    parameter int CW       = 26
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       pause_i,
    input  logic       cfg_valid_i,
    input  logic [1:0] cfg_ch_i,
    input  logic [7:0] cfg_div_i,
    input  logic       cfg_oneshot_i,
    output logic       cfg_ready_o,
    output logic       base_tick_o,
    output logic [3:0] ch_event_o,
    output logic [3:0] ch_active_o
);

    localparam logic [CW-1:0] BCOUNT_LAST = CW'(BASE_DIV - 1);

    logic [CW-1:0]   bcount_q,    bcount_d;
    logic            base_tick_q, base_tick_d;
    logic            rst_flag_q;
    logic [3:0][7:0] cnt_q,       cnt_d;
    logic [3:0][7:0] div_q,       div_d;
    logic [3:0]      mode_q,      mode_d;
    logic [3:0]      active_q,    active_d;
    logic [3:0]      event_q,     event_d;
    logic            cfg_accept;

    // Ready is withheld on tick cycles so a config write never races a decrement.
    assign cfg_ready_o = ~rst_flag_q & ~base_tick_q;
    assign cfg_accept  = cfg_valid_i & cfg_ready_o;

    always_comb begin
        bcount_d    = bcount_q;
        base_tick_d = 1'b0;
        if (!pause_i) begin
            if (bcount_q == BCOUNT_LAST) begin
                bcount_d    = '0;
                base_tick_d = 1'b1;
            end else begin
                bcount_d = bcount_q + CW'(1);
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        mode_d   = mode_q;
        active_d = active_q;
        event_d  = '0;
        for (int n = 0; n < 4; n++) begin
            if (base_tick_q && active_q[n]) begin
                if (cnt_q[n] == 8'd1) begin
                    event_d[n] = 1'b1;
                    if (mode_q[n]) begin
                        active_d[n] = 1'b0;
                        cnt_d[n]    = 8'd0;
                    end else begin
                        cnt_d[n] = div_q[n];
                    end
                end else begin
                    cnt_d[n] = cnt_q[n] - 8'd1;
                end
            end
            if (cfg_accept && (cfg_ch_i == 2'(n))) begin
                if (cfg_div_i != 8'd0) begin
                    div_d[n]    = cfg_div_i;
                    cnt_d[n]    = cfg_div_i;
                    mode_d[n]   = cfg_oneshot_i;
                    active_d[n] = 1'b1;
                end else begin
                    active_d[n] = 1'b0;
                    cnt_d[n]    = 8'd0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bcount_q    <= '0;
            base_tick_q <= 1'b0;
            rst_flag_q  <= 1'b1;
            cnt_q       <= '0;
            div_q       <= '0;
            mode_q      <= '0;
            active_q    <= '0;
            event_q     <= '0;
        end else begin
            bcount_q    <= bcount_d;
            base_tick_q <= base_tick_d;
            rst_flag_q  <= 1'b0;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            mode_q      <= mode_d;
            active_q    <= active_d;
            event_q     <= event_d;
        end
    end

    assign base_tick_o = base_tick_q;
    assign ch_event_o  = event_q;
    assign ch_active_o = active_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: a tick-counting reference model queues
// the expected outputs for every cycle, a negedge monitor compares them.
module tb_tick_scheduler;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1, pause_i = 1'b0, cfg_valid_i = 1'b0, cfg_oneshot_i = 1'b0;
    logic [1:0] cfg_ch_i = '0;
    logic [7:0] cfg_div_i = '0;
    logic       cfg_ready_o, base_tick_o;
    logic [3:0] ch_event_o, ch_active_o;

    always #5 clk = ~clk;

    tick_scheduler #(.BASE_DIV(BD), .CW(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .pause_i(pause_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ch_i(cfg_ch_i), .cfg_div_i(cfg_div_i),
        .cfg_oneshot_i(cfg_oneshot_i), .cfg_ready_o(cfg_ready_o),
        .base_tick_o(base_tick_o), .ch_event_o(ch_event_o), .ch_active_o(ch_active_o)
    );

    typedef struct packed {
        logic       tick;
        logic [3:0] ev;
        logic [3:0] act;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0, n_miss = 0, mon_cyc = 0;

    // Reference model: whole unpaused cycles modulo BD, ticks remaining per channel.
    bit       m_rflag = 1'b1;
    bit       m_tick  = 1'b0;
    int       m_pre   = 0;
    int       m_rem[4];
    int       m_per[4];
    bit       m_one[4];
    bit [3:0] m_act = '0;
    bit [3:0] m_ev  = '0;

    task automatic step(input bit r, input bit p, input bit v, input int ch,
                        input int dv, input bit os, output bit acc);
        exp_t e;
        bit   rdy;
        rdy = !m_rflag && !m_tick;
        acc = 1'b0;
        reset_i = r; pause_i = p; cfg_valid_i = v;
        cfg_ch_i = 2'(ch); cfg_div_i = 8'(dv); cfg_oneshot_i = os;
        if (r) begin
            m_rflag = 1'b1; m_tick = 1'b0; m_pre = 0; m_act = '0; m_ev = '0;
            for (int n = 0; n < 4; n++) begin m_rem[n] = 0; m_per[n] = 0; m_one[n] = 1'b0; end
        end else begin
            m_ev = '0;
            if (m_tick) begin
                for (int n = 0; n < 4; n++) begin
                    if (m_act[n]) begin
                        m_rem[n] = m_rem[n] - 1;
                        if (m_rem[n] == 0) begin
                            m_ev[n] = 1'b1;
                            if (m_one[n]) m_act[n] = 1'b0;
                            else          m_rem[n] = m_per[n];
                        end
                    end
                end
            end
            if (v && rdy) begin
                acc = 1'b1;
                if (dv != 0) begin
                    m_per[ch] = dv; m_rem[ch] = dv; m_one[ch] = os; m_act[ch] = 1'b1;
                end else begin
                    m_act[ch] = 1'b0; m_rem[ch] = 0;
                end
            end
            m_tick = !p && (m_pre == BD - 1);
            if (!p) m_pre = (m_pre + 1) % BD;
            m_rflag = 1'b0;
        end
        e.tick = m_tick; e.ev = m_ev; e.act = m_act; e.rdy = !m_rflag && !m_tick;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic do_reset(input int n);
        bit a;
        repeat (n) step(1, 0, 0, 0, 0, 0, a);
    endtask

    task automatic pause_for(input int n);
        bit a;
        repeat (n) step(0, 1, 0, 0, 0, 0, a);
    endtask

    task automatic wait_tick();
        int g = 0;
        while (!m_tick && g < 2 * BD) begin idle(1); g++; end
    endtask

    // Holds the request until the model says it is accepted.
    task automatic cfg_write(input int ch, input int dv, input bit os);
        bit acc = 1'b0;
        int g = 0;
        while (!acc && g < 8) begin step(0, 0, 1, ch, dv, os, acc); g++; end
    endtask

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, mon_cyc, got, want);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                mon_cyc++;
                chk("base_tick", {3'b0, base_tick_o}, {3'b0, e.tick});
                chk("ch_event",  ch_event_o,           e.ev);
                chk("ch_active", ch_active_o,          e.act);
                chk("cfg_ready", {3'b0, cfg_ready_o},  {3'b0, e.rdy});
            end
        end
    end

    initial begin
        bit a;
        int dv;
        // reset then idle
        do_reset(2);
        idle(20);
        // ch0 periodic div 3
        cfg_write(0, 3, 0);
        idle(30);
        // ch2 one-shot div 1
        cfg_write(2, 1, 1);
        idle(40);
        // ch0 and ch1 div 2 in the same inter-tick gap
        wait_tick();
        idle(1);
        cfg_write(0, 2, 0);
        cfg_write(1, 2, 0);
        idle(20);
        cfg_write(1, 0, 0);
        idle(20);
        // request held across a tick cycle
        wait_tick();
        cfg_write(3, 5, 0);
        repeat (4) begin wait_tick(); idle(1); end
        cfg_write(3, 2, 0);
        idle(20);
        // pause mid-count, then reset mid-count
        cfg_write(0, 3, 0);
        idle(6);
        pause_for(7);
        idle(20);
        cfg_write(1, 2, 1);
        idle(5);
        do_reset(1);
        idle(12);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            dv = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 3), dv,
                 $urandom_range(0, 1), a);
        end
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d queued expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Shared game-timing scheduler built around one base prescaler: a single free-running clock divider produces a base tick (4 Hz at 50 MHz by default), and four independently programmed channels count base ticks to raise one-cycle event strobes. Game logic uses these strobes for sprite movement, spawn timers and similar timed events. One prescaler serves all four channels, so the design has no per-feature 26-bit counters.

## Interface
- BASE_DIV, 12500000: clk cycles per base tick; legal range 2..2^26-1.
- CW, 26: prescaler counter width; must hold BASE_DIV-1.
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- pause  in  1  when 1, the prescaler holds its value. Channel state is retained.
- cfg_valid  in  1  configuration request.
- cfg_ch  in  2  target channel 0..3.
- cfg_div  in  8  base ticks per event; 0 stops the channel.
- cfg_oneshot  in  1  0 = periodic, 1 = fire once then deactivate.
- cfg_ready  out  1  config accepted on the edge where cfg_valid & cfg_ready.
- base_tick  out  1  one-cycle pulse per BASE_DIV unpaused cycles.
- ch_event  out  4  per-channel one-cycle event pulse.
- ch_active  out  4  channel is counting.

## Operation
- Reset values: bcount=0, base_tick=0, ch_event=0, ch_active=0, all channel counters and divisors 0, cfg_ready=0.
- Prescaler: on each edge with pause=0, bcount increments.
  - At bcount==BASE_DIV-1, bcount wraps to 0 and base_tick is registered 1 for the next cycle.
  - Otherwise base_tick=0.
  - With pause=1, bcount holds and base_tick is registered 0.
- cfg_ready = 0 in the cycle after reset and in any cycle where base_tick==1; otherwise 1.
  - Consequence: a configuration write never coincides with channel decrement.
- Config accept (cfg_valid & cfg_ready), channel n = cfg_ch:
  - cfg_div != 0: div[n]=cfg_div, cnt[n]=cfg_div, mode[n]=cfg_oneshot, ch_active[n]=1. Restarts an already-active channel and discards its old count; no event is produced for the old schedule.
  - cfg_div == 0: ch_active[n]=0 and cnt[n]=0.
  - Other channels are untouched.
- Channel update, only in cycles with base_tick==1, for each active channel n:
  - cnt[n]==1: ch_event[n] is registered 1 for the next cycle.
    - Periodic mode: cnt[n]=div[n].
    - One-shot mode: ch_active[n]=0 and cnt[n]=0.
  - Otherwise cnt[n] decrements by 1.
- Inactive channels never pulse. Multiple channels expiring on the same base tick pulse in the same cycle.
- Counter arithmetic: 8-bit unsigned; cnt never underflows because the reload/decrement decision is made at 1.
- Reset asserted mid-operation: all state clears on that edge and any pending event is dropped.
- While pause=1, channels are frozen implicitly (no base ticks) and config writes are still accepted.

## Timing
- Reset is released at edge E0 (first edge with reset=0); pause=0 throughout.
  - cfg_ready rises after E0.
  - base_tick is high during the cycle after edge E0+BASE_DIV-1, then every BASE_DIV cycles.
- Event latency: ch_event[n] is high in the cycle immediately after the D-th base_tick cycle that follows config acceptance, where D = cfg_div.
- ch_active[n] falls (one-shot) on the same edge that raises ch_event[n].
- All outputs are registered except cfg_ready, which is decoded from the base_tick register and a reset-flag register.
- Pause for P cycles delays all subsequent base ticks and events by exactly P cycles.

## Test plan
All scenarios use BASE_DIV=4.
- Reset then idle 20 cycles -> base_tick pulses every 4 cycles; ch_event=0 and ch_active=0 throughout; cfg_ready=0 in the first cycle, then low exactly on base_tick cycles.
- Config ch0 div=3, periodic -> ch_event[0] pulses once every 12 cycles, one cycle after every 3rd base_tick; ch_active[0] stays 1.
- Config ch2 div=1, one-shot -> single ch_event[2] pulse after the next base_tick; ch_active[2] falls on that edge; no further pulses over 40 cycles.
- Channels 0,1 each div=2 configured in the same inter-tick gap -> ch_event=4'b0011 in the same cycle. Then write ch1 div=0 -> ch1 is silent from then on and ch0 is unaffected.
- Hold cfg_valid during a base_tick cycle -> not accepted that cycle, accepted the next. Reconfigure active ch3 from div=5 to div=2 when cnt=1 -> no old event; new event after 2 ticks.
- Pause 7 cycles mid-count -> base_tick and ch_event timing shifted by exactly 7 cycles. Assert reset mid-count -> all outputs 0 next cycle and no stale event.
